// File: rtl/dijkstra_pkg.sv
// rtl/dijkstra_pkg.sv - shared constants, walk FSM states and address helper for the Dijkstra datapath
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif

package dijkstra_pkg;

    // Marker the core writes into prev[] for nodes with no predecessor; users truncate to INDEX_WIDTH.
    localparam logic [31:0] NO_PREVIOUS_NODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        READ,
        OUTPUT,
        DONE,
        ERROR
    } state_t;

    function automatic int unsigned word_stride(input int unsigned maddr_width);
        return maddr_width / 8;
    endfunction

endpackage

// File: rtl/path_tracer_if.sv
// rtl/path_tracer_if.sv - memory read port and path output stream of the path tracer
interface path_tracer_if #(
    parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) ();

    logic                   mem_read_enable;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic                   mem_read_ready;
    logic [MDATA_WIDTH-1:0] mem_read_data;

    logic [INDEX_WIDTH-1:0] path_node;
    logic                   path_valid;
    logic                   path_ready;
    logic                   path_last;

    modport master (
        output mem_read_enable, mem_addr,
        input  mem_read_ready, mem_read_data,
        output path_node, path_valid, path_last,
        input  path_ready
    );

    modport slave (
        input  mem_read_enable, mem_addr,
        output mem_read_ready, mem_read_data,
        input  path_node, path_valid, path_last,
        output path_ready
    );

endinterface

// File: rtl/path_stack.sv
// rtl/path_stack.sv - synchronous LIFO that reverses the prev[] walk into source-first order
module path_stack #(
    parameter int unsigned DEPTH = `DEFAULT_MAX_NODES,
    parameter int unsigned WIDTH = `DEFAULT_INDEX_WIDTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    wr_index;
    logic [AW-1:0]    top_index;

    assign wr_index  = AW'(sp);
    assign top_index = AW'(sp - CW'(1));
    assign top_data  = mem[top_index];
    assign empty     = (sp == '0);
    assign count     = sp;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && (sp != CW'(DEPTH))) begin
            mem[wr_index] <= push_data;
            sp            <= sp + CW'(1);
        end else if (pop && !empty) begin
            sp <= sp - CW'(1);
        end
    end

endmodule

// File: rtl/path_tracer.sv
// rtl/path_tracer.sv - walks prev[] from destination to source and streams the route; PATH_TRACER_FORWARD_ORDER_EN selects source-first order
module path_tracer
    import dijkstra_pkg::*;
#(
    parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    path_tracer_if.master          bus,
    output logic [INDEX_WIDTH-1:0] path_length,
    output logic                   path_error,
    output logic                   done,
    output logic                   ready
);

    localparam int unsigned STRIDE = word_stride(MADDR_WIDTH);
    localparam int unsigned NNW    = 2 * INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] NPN = INDEX_WIDTH'(NO_PREVIOUS_NODE);

    state_t state, state_next;

    logic [INDEX_WIDTH-1:0] src_q, n_q, cur, count, count_inc, prev_node;
    logic [MADDR_WIDTH-1:0] base_q;
    logic [NNW-1:0]         nn_q;
    logic [NNW:0]           word_index;
    logic                   err_q, start, record, rd_fire, prev_bad, bad_args;
    logic                   rd_en, out_valid, out_last;
    logic [INDEX_WIDTH-1:0] out_node;
    logic                   unused_data;

`ifdef PATH_TRACER_FORWARD_ORDER_EN
    localparam int unsigned SW = $clog2(MAX_NODES + 1);
    localparam state_t AT_SOURCE = OUTPUT;

    logic                   pop, stack_empty;
    logic [INDEX_WIDTH-1:0] stack_top;
    logic [SW-1:0]          stack_count;

    path_stack #(
        .DEPTH (MAX_NODES),
        .WIDTH (INDEX_WIDTH)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .clear     (start),
        .push      (record),
        .pop       (pop),
        .push_data (cur),
        .top_data  (stack_top),
        .empty     (stack_empty),
        .count     (stack_count)
    );

    // The stack cannot hold a graph larger than MAX_NODES, so such a request is rejected up front.
    assign bad_args = (destination >= number_of_nodes) || (source >= number_of_nodes)
                   || (32'(number_of_nodes) > MAX_NODES);
`else
    localparam state_t AT_SOURCE = DONE;

    assign bad_args = (destination >= number_of_nodes) || (source >= number_of_nodes);
`endif

    assign start       = (state == IDLE) && enable;
    assign count_inc   = count + INDEX_WIDTH'(1);
    assign rd_fire     = (state == READ) && bus.mem_read_ready;
    assign prev_node   = bus.mem_read_data[INDEX_WIDTH-1:0];
    assign prev_bad    = (prev_node == NPN) || (prev_node >= n_q);
    assign unused_data = ^bus.mem_read_data;

    // prev[j] lives N*N words past the base, after the adjacency matrix.
    assign word_index  = {1'b0, nn_q} + {{(NNW - INDEX_WIDTH + 1){1'b0}}, cur};
    assign bus.mem_addr = base_q + MADDR_WIDTH'(word_index) * MADDR_WIDTH'(STRIDE);

    assign bus.mem_read_enable = rd_en;
    assign bus.path_valid      = out_valid;
    assign bus.path_node       = out_node;
    assign bus.path_last       = out_last;

    assign ready       = (state == IDLE);
    assign done        = (state == DONE) || (state == ERROR);
    assign path_length = count;
    assign path_error  = err_q;

    always_comb begin
        state_next = state;
        record     = 1'b0;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        out_node   = '0;
        out_last   = 1'b0;
`ifdef PATH_TRACER_FORWARD_ORDER_EN
        pop        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enable) state_next = bad_args ? ERROR : WALK;
            end
            WALK: begin
`ifdef PATH_TRACER_FORWARD_ORDER_EN
                record    = 1'b1;
`else
                // Unbuffered: cur goes straight out and the walk waits for the consumer.
                out_valid = 1'b1;
                out_node  = cur;
                out_last  = (cur == src_q);
                record    = bus.path_ready;
`endif
                if (record) begin
                    if (cur == src_q)          state_next = AT_SOURCE;
                    else if (count_inc == n_q) state_next = ERROR;
                    else                       state_next = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (bus.mem_read_ready) state_next = prev_bad ? ERROR : WALK;
            end
            OUTPUT: begin
`ifdef PATH_TRACER_FORWARD_ORDER_EN
                out_valid = !stack_empty;
                out_node  = stack_top;
                out_last  = (stack_count == SW'(1));
                pop       = bus.path_ready;
                if (bus.path_ready && out_last) state_next = DONE;
`else
                state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            src_q  <= '0;
            n_q    <= '0;
            base_q <= '0;
            nn_q   <= '0;
            cur    <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                src_q  <= source;
                n_q    <= number_of_nodes;
                base_q <= base_address;
                nn_q   <= NNW'(number_of_nodes) * NNW'(number_of_nodes);
                cur    <= destination;
                count  <= '0;
                err_q  <= 1'b0;
            end
            if (record) count <= count_inc;
            if (rd_fire && !prev_bad) cur <= prev_node;
            if (state_next == ERROR) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_path_tracer.sv
// tb/tb_path_tracer.sv - directed self-checking bench for path_tracer
module tb_path_tracer;

    localparam int MAW  = 32;
    localparam int MDW  = 32;
    localparam int MAXN = 16;
    localparam int IW   = 8;
    localparam logic [IW-1:0]  NPN  = 8'hFF;
    localparam logic [MAW-1:0] BASE = 32'h0000_0100;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [IW-1:0]  source = '0;
    logic [IW-1:0]  destination = '0;
    logic [IW-1:0]  number_of_nodes = '0;
    logic [MAW-1:0] base_address = '0;
    logic [IW-1:0]  path_length;
    logic           path_error;
    logic           done;
    logic           ready;

    always #5 clock = ~clock;

    path_tracer_if #(.MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW), .INDEX_WIDTH(IW)) bus ();

    path_tracer #(
        .MADDR_WIDTH (MAW),
        .MDATA_WIDTH (MDW),
        .MAX_NODES   (MAXN),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .source          (source),
        .destination     (destination),
        .number_of_nodes (number_of_nodes),
        .base_address    (base_address),
        .bus             (bus),
        .path_length     (path_length),
        .path_error      (path_error),
        .done            (done),
        .ready           (ready)
    );

    int errors = 0;
    int checks = 0;

    logic [IW-1:0]  prev_mem [MAXN];
    int             cur_n = 8;
    int             rd_latency = 1;
    int             ready_period = 1;
    int             cyc = 0;
    int             wait_cnt = 0;
    bit             req_active = 0;
    logic [MAW-1:0] req_addr = '0;
    bit             hold_pending = 0;
    logic [IW-1:0]  hold_node = '0;
    logic           hold_last = 1'b0;

    int             beats [$];
    bit             lasts [$];
    logic [MAW-1:0] read_addrs [$];
    int             exp_q [$];
    int             read_count, read_cycles, done_count, addr_viol, beat_viol;
    logic [IW-1:0]  len_seen;
    logic           err_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] lookup(input logic [MAW-1:0] addr);
        int w;
        w = int'((addr - BASE) >> 2) - cur_n * cur_n;
        if (w >= 0 && w < MAXN) return prev_mem[w];
        return NPN;
    endfunction

    // Memory responder, stream sink and done monitor, all sampled on the falling edge.
    initial begin
        bus.mem_read_ready = 1'b0;
        bus.mem_read_data  = '0;
        bus.path_ready     = 1'b1;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset || bus.mem_read_ready || !bus.mem_read_enable) begin
                bus.mem_read_ready = 1'b0;
                wait_cnt   = 0;
                req_active = 0;
            end else begin
                read_cycles++;
                if (!req_active) begin
                    req_active = 1;
                    req_addr   = bus.mem_addr;
                end else if (bus.mem_addr != req_addr) begin
                    addr_viol++;
                end
                wait_cnt++;
                if (wait_cnt >= rd_latency) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data  = {24'hA5A5A5, lookup(bus.mem_addr)};
                    read_addrs.push_back(bus.mem_addr);
                    read_count++;
                end
            end

            bus.path_ready = (ready_period <= 1) ? 1'b1 : ((cyc % ready_period) == 0);
            if (hold_pending && reset &&
                (!bus.path_valid || bus.path_node != hold_node || bus.path_last != hold_last))
                beat_viol++;
            if (reset && bus.path_valid) begin
                if (bus.path_ready) begin
                    beats.push_back(int'(bus.path_node));
                    lasts.push_back(bus.path_last);
                    hold_pending = 0;
                end else begin
                    hold_pending = 1;
                    hold_node    = bus.path_node;
                    hold_last    = bus.path_last;
                end
            end else begin
                hold_pending = 0;
            end

            if (reset && done) begin
                done_count++;
                len_seen = path_length;
                err_seen = path_error;
            end
        end
    end

    task automatic clear_log();
        beats.delete();
        lasts.delete();
        read_addrs.delete();
        read_count  = 0;
        read_cycles = 0;
        done_count  = 0;
        addr_viol   = 0;
        beat_viol   = 0;
        len_seen    = '0;
        err_seen    = 1'b0;
    endtask

    task automatic init_prev();
        for (int i = 0; i < MAXN; i++) prev_mem[i] = NPN;
        prev_mem[1] = 8'd0; prev_mem[2] = 8'd1; prev_mem[3] = 8'd1;
        prev_mem[4] = 8'd2; prev_mem[5] = 8'd3; prev_mem[6] = 8'd4; prev_mem[7] = 8'd5;
    endtask

    task automatic start_run(input logic [IW-1:0] s, input logic [IW-1:0] d, input logic [IW-1:0] n);
        clear_log();
        @(negedge clock);
        source          = s;
        destination     = d;
        number_of_nodes = n;
        base_address    = BASE;
        cur_n           = int'(n);
        enable          = 1'b1;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_count == 0 && t < 2000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        check_eq({tag, "_done_pulse"}, done_count, 1);
        check_eq({tag, "_ready_after"}, ready, 1);
    endtask

    task automatic check_path(input string tag, input bit last_on_final);
        check_eq({tag, "_beats"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            check_eq($sformatf("%s_node%0d", tag, i), beats[i], exp_q[i]);
            check_eq($sformatf("%s_last%0d", tag, i), lasts[i],
                     (last_on_final && i == exp_q.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic check_walk(input string tag);
`ifdef PATH_TRACER_FORWARD_ORDER_EN
        exp_q = '{0, 1, 3, 5, 7};
`else
        exp_q = '{7, 5, 3, 1, 0};
`endif
        check_path(tag, 1);
        check_eq({tag, "_length"}, len_seen, 5);
        check_eq({tag, "_error"}, err_seen, 0);
        check_eq({tag, "_reads"}, read_addrs.size(), 4);
        if (read_addrs.size() == 4) begin
            check_eq({tag, "_addr0"}, read_addrs[0], 32'h21C);
            check_eq({tag, "_addr1"}, read_addrs[1], 32'h214);
            check_eq({tag, "_addr2"}, read_addrs[2], 32'h20C);
            check_eq({tag, "_addr3"}, read_addrs[3], 32'h204);
        end
        check_eq({tag, "_addr_stable"}, addr_viol, 0);
        check_eq({tag, "_beat_stable"}, beat_viol, 0);
    endtask

    initial begin
        init_prev();
        clear_log();
        repeat (3) @(negedge clock);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", bus.path_valid, 0);
        check_eq("rst_rd_en", bus.mem_read_enable, 0);
        check_eq("rst_error", path_error, 0);
        check_eq("rst_length", path_length, 0);
        reset = 1'b1;
        @(negedge clock);

        start_run(8'd0, 8'd7, 8'd8);
        wait_done("walk");
        check_walk("walk");

        start_run(8'd3, 8'd3, 8'd8);
        wait_done("trivial");
        exp_q = '{3};
        check_path("trivial", 1);
        check_eq("trivial_length", len_seen, 1);
        check_eq("trivial_rd_cycles", read_cycles, 0);
        check_eq("trivial_error", err_seen, 0);

        prev_mem[7] = NPN;
        start_run(8'd0, 8'd7, 8'd8);
        wait_done("unreach");
        check_eq("unreach_error", err_seen, 1);
        check_eq("unreach_reads", read_count, 1);
`ifdef PATH_TRACER_FORWARD_ORDER_EN
        exp_q.delete();
`else
        exp_q = '{7};
`endif
        check_path("unreach", 0);

        prev_mem[7] = 8'd6;
        prev_mem[6] = 8'd7;
        start_run(8'd0, 8'd7, 8'd8);
        wait_done("loop");
        check_eq("loop_error", err_seen, 1);
        check_eq("loop_reads", read_count, 7);
`ifdef PATH_TRACER_FORWARD_ORDER_EN
        exp_q.delete();
`else
        exp_q = '{7, 6, 7, 6, 7, 6, 7, 6};
`endif
        check_path("loop", 0);

        start_run(8'd0, 8'd9, 8'd8);
        wait_done("badidx");
        check_eq("badidx_error", err_seen, 1);
        check_eq("badidx_rd_cycles", read_cycles, 0);
        check_eq("badidx_beats", beats.size(), 0);

        init_prev();
        ready_period = 3;
        rd_latency   = 3;
        start_run(8'd0, 8'd7, 8'd8);
        wait_done("bp");
        check_walk("bp");
        ready_period = 1;

        rd_latency = 20;
        start_run(8'd0, 8'd7, 8'd8);
        repeat (3) @(negedge clock);
        check_eq("rstmid_in_read", bus.mem_read_enable, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_eq("rstmid_rd_en", bus.mem_read_enable, 0);
        check_eq("rstmid_ready", ready, 1);
        check_eq("rstmid_valid", bus.path_valid, 0);
        rd_latency = 1;
        start_run(8'd0, 8'd7, 8'd8);
        wait_done("rerun");
        check_walk("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/path_tracer.md
Name: path_tracer

Overview:
- Downstream consumer of the Dijkstra core.
- Once the core reports ready, this block walks the predecessor ("prev") array that the core left in block RAM, starting at the destination and following it back to the source.
- It emits the resulting node sequence on a valid/ready stream for the route-output logic.
- It shares the core's memory read interface and address map (prev[j] at base + (N*N + j) words).

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: memory address/word width; word stride = MADDR_WIDTH/8.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: memory read-data width.
- MAX_NODES, `DEFAULT_MAX_NODES: maximum graph size; sets path buffer depth.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: node index width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  start request; accepted when ready=1.
- source  in  INDEX_WIDTH  path start node.
- destination  in  INDEX_WIDTH  path end node; the walk begins here.
- number_of_nodes  in  INDEX_WIDTH  graph size N.
- base_address  in  MADDR_WIDTH  graph base address.
- mem_read_enable  out  1  read request; held until mem_read_ready.
- mem_addr  out  MADDR_WIDTH  read address.
- mem_read_ready  in  1  read data valid this cycle.
- mem_read_data  in  MDATA_WIDTH  read data; bits [INDEX_WIDTH-1:0] used.
- path_node  out  INDEX_WIDTH  emitted node.
- path_valid  out  1  path_node valid.
- path_ready  in  1  consumer accepts the beat.
- path_last  out  1  final beat of the path.
- path_length  out  INDEX_WIDTH  number of nodes in the path; valid when done=1.
- path_error  out  1  unreachable node, loop, or bad index; sticky until next start.
- done  out  1  one-cycle pulse at completion (success or error).
- ready  out  1  idle, able to accept enable.

Behaviour:
- Reset (reset=0 at posedge):
  - ready=1; every other output 0.
  - Stack pointer and hop count cleared; state IDLE.
  - Applies from any state. mem_read_enable and path_valid drop the cycle after.
- IDLE:
  - On enable&&ready: latch source, destination, N and base_address.
  - Compute NN=N*N once into a register; cur=destination; count=0; clear path_error; ready=0.
  - If destination>=N or source>=N -> ERROR; else -> WALK.
- WALK (1 cycle):
  - Record cur (push, or emit per feature); count++.
  - If cur==source -> OUTPUT.
  - Else if count==N -> ERROR (loop guard); else -> READ.
- READ:
  - mem_read_enable=1; mem_addr=base+(NN+cur)*(MADDR_WIDTH/8), truncated mod 2^MADDR_WIDTH.
  - Both held stable until the posedge where mem_read_ready=1, at which point capture p=mem_read_data[INDEX_WIDTH-1:0]. mem_read_enable=0 the following cycle.
  - If p==`NO_PREVIOUS_NODE or p>=N -> ERROR; else cur=p -> WALK.
- OUTPUT:
  - Pop the stack. path_valid=1; path_last=1 on the final element.
  - path_node and path_last stay stable while path_valid&&!path_ready.
  - The next element is presented the cycle after a transfer. After the last transfer -> DONE.
- DONE: done=1 for one cycle; path_length=count; -> IDLE (ready=1 next cycle).
- ERROR: path_error=1; done=1 for one cycle; path_valid=0; -> IDLE.
- Edge cases:
  - enable while ready=0 is ignored.
  - source==destination gives a one-beat path with zero memory reads.
- Latency: one WALK cycle plus the read wait per hop; at least 2 cycles/hop when mem_read_ready returns on the first cycle.

Optional Feature:
- Macro: PATH_TRACER_FORWARD_ORDER_EN.
- Defined:
  - A MAX_NODES x INDEX_WIDTH LIFO buffers the walk.
  - Output order is source...destination; no beats are emitted on error.
- Undefined:
  - No buffer. WALK presents cur directly on the stream and stalls until the transfer before continuing.
  - Order is destination...source; path_last is asserted on the source beat.
  - On error, beats already emitted stand; the consumer discards them on path_error.

Decomposition:
- Shared package dijkstra_pkg holds:
  - NO_PREVIOUS_NODE, moved out of constants.v;
  - the state enum (IDLE, WALK, READ, OUTPUT, DONE, ERROR);
  - the address-stride helper function.
- Sub-module path_stack: synchronous LIFO with push/pop/empty/count, depth MAX_NODES. Instantiated only under PATH_TRACER_FORWARD_ORDER_EN.

Test Plan:
- Walk with no stall: N=8, source=0, destination=7, prev=[NPN,0,1,1,2,3,4,5], path_ready=1, mem_read_ready one cycle after request.
  - Required: beats 0,1,3,5,7; path_last with 7; path_length=5; done pulse; path_error=0; 4 reads at addresses 64+{7,5,3,1} words.
- Trivial path: source=destination=3.
  - Required: single beat 3 with path_last; path_length=1; zero mem_read_enable cycles.
- Unreachable: prev[7]=NO_PREVIOUS_NODE, source=0.
  - Required: path_error=1 and done after 1 read; no beats in forward mode.
- Loop: prev[7]=6, prev[6]=7, source=0, N=8.
  - Required: path_error after count reaches 8; at most 7 reads; FSM back in IDLE.
- Backpressure: path_ready high every third cycle; mem_read_ready delayed 3 cycles.
  - Required: same sequence as the no-stall walk; path_node and mem_addr stable during stalls; no dropped or duplicated beat.
- Reset mid-READ: reset=0 during a read, then a fresh start.
  - Required: mem_read_enable=0 and ready=1 after reset; next run produces the correct no-stall sequence.
